// File: rtl/pd_pkg.sv
// Shared USB PD constants: message encodings, sink policy-engine state codes
// and default timer periods, used by both source and sink policy engines.
package pd_pkg;

  localparam logic [1:0] MSG_CLASS_CTRL = 2'b00;
  localparam logic [1:0] MSG_CLASS_DATA = 2'b01;

  localparam logic [4:0] CTRL_GOODCRC = 5'd1;
  localparam logic [4:0] CTRL_ACCEPT  = 5'd3;
  localparam logic [4:0] CTRL_REJECT  = 5'd4;
  localparam logic [4:0] CTRL_PS_RDY  = 5'd6;
  localparam logic [4:0] CTRL_WAIT    = 5'd12;

  localparam logic [4:0] DATA_SOURCE_CAP = 5'd1;
  localparam logic [4:0] DATA_REQUEST    = 5'd2;

  localparam int unsigned T_SINKWAITCAP_DEFAULT    = 620000;
  localparam int unsigned T_SENDERRESPONSE_DEFAULT = 30000;
  localparam int unsigned T_PSTRANSITION_DEFAULT   = 500000;
  localparam int unsigned N_HARDRESETCOUNT         = 2;
  localparam int unsigned TIMER_W_DEFAULT          = 20;

  typedef enum logic [3:0] {
    PE_SNK_STARTUP               = 4'd0,
    PE_SNK_DISCOVERY             = 4'd1,
    PE_SNK_WAIT_FOR_CAPS         = 4'd2,
    PE_SNK_EVALUATE_CAP          = 4'd3,
    PE_SNK_SELECT_CAP            = 4'd4,
    PE_SNK_TRANSITION_SINK       = 4'd5,
    PE_SNK_READY                 = 4'd6,
    PE_SNK_HARD_RESET            = 4'd7,
    PE_SNK_TRANSITION_TO_DEFAULT = 4'd8,
    PE_SNK_ERROR                 = 4'd9
  } pe_snk_state_t;

  function automatic logic [6:0] msg_code(input logic [1:0] cls, input logic [4:0] typ);
    return {cls, typ};
  endfunction

endpackage

// File: rtl/pd_pe_timer.sv
// One-shot down-counter for policy-engine timers: loading N yields a single
// timeout pulse N cycles after the load cycle; clear disarms.
module pd_pe_timer #(
  parameter int unsigned TIMER_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               clear,
  output logic               timeout
);

  logic [TIMER_W-1:0] cnt;
  logic               armed;

  assign timeout = armed && (cnt == '0);

  // Counter holds N-1 after the load edge so it reaches zero in cycle N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val - 1'b1;
      armed <= (load_val != '0);
    end else if (timeout) begin
      armed <= 1'b0;
    end else if (armed) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pd_snk_policy_engine.sv
// USB PD sink policy engine: waits for Source_Capabilities, requests power via
// the DPM, tracks the contract and handles hard reset and detach.
module pd_snk_policy_engine
  import pd_pkg::*;
#(
  parameter int unsigned T_SINKWAITCAP      = T_SINKWAITCAP_DEFAULT,
  parameter int unsigned T_SENDERRESPONSE   = T_SENDERRESPONSE_DEFAULT,
  parameter int unsigned T_PSTRANSITION     = T_PSTRANSITION_DEFAULT,
  parameter int unsigned NUM_HARDRESETCOUNT = N_HARDRESETCOUNT,
  parameter int unsigned TIMER_W            = TIMER_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       DPM2PE_attached,
  input  logic       DPM2PE_vbus_present,
  input  logic       DPM2PE_eval_done,
  input  logic       DPM2PE_trans_finish,
  input  logic       PL2PE_reset_done,
  input  logic       PL2PE_Rx_en,
  input  logic [6:0] PL2PE_Rx_type,
  input  logic       PL2PE_Rx_hard_reset,
  input  logic       PL2PE_Tx_ack,
  input  logic [1:0] PL2PE_Tx_result,
  output logic       PE2PL_Tx_en,
  output logic [6:0] PE2PL_Tx_type,
  output logic       PE2PL_reset_req,
  output logic       PE2PL_hard_reset_req,
  output logic       PE2DPM_eval_req,
  output logic       PE2DPM_hard_reset,
  output logic       PE2DPM_contract_valid,
  output logic [3:0] pe_state
);

  localparam logic [TIMER_W-1:0] LD_SINKWAITCAP    = TIMER_W'(T_SINKWAITCAP);
  localparam logic [TIMER_W-1:0] LD_SENDERRESPONSE = TIMER_W'(T_SENDERRESPONSE);
  localparam logic [TIMER_W-1:0] LD_PSTRANSITION   = TIMER_W'(T_PSTRANSITION);
  localparam logic [2:0]         HR_LIMIT          = 3'(NUM_HARDRESETCOUNT);

  pe_snk_state_t      state;
  pe_snk_state_t      state_next;
  logic               state_changed;
  logic               entry;
  logic [2:0]         hr_cnt;
  logic               detach;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timeout;

  logic rx_is_ctrl;
  logic rx_is_data;
  logic rx_msg;
  logic rx_src_cap;
  logic rx_accept;
  logic rx_reject;
  logic rx_wait;
  logic rx_ps_rdy;
  logic tx_ok;
  logic tx_fail;

  assign rx_is_ctrl = PL2PE_Rx_en && (PL2PE_Rx_type[6:5] == MSG_CLASS_CTRL);
  assign rx_is_data = PL2PE_Rx_en && (PL2PE_Rx_type[6:5] == MSG_CLASS_DATA);
  assign rx_msg     = PL2PE_Rx_en && !(rx_is_ctrl && PL2PE_Rx_type[4:0] == CTRL_GOODCRC);
  assign rx_src_cap = rx_is_data && (PL2PE_Rx_type[4:0] == DATA_SOURCE_CAP);
  assign rx_accept  = rx_is_ctrl && (PL2PE_Rx_type[4:0] == CTRL_ACCEPT);
  assign rx_reject  = rx_is_ctrl && (PL2PE_Rx_type[4:0] == CTRL_REJECT);
  assign rx_wait    = rx_is_ctrl && (PL2PE_Rx_type[4:0] == CTRL_WAIT);
  assign rx_ps_rdy  = rx_is_ctrl && (PL2PE_Rx_type[4:0] == CTRL_PS_RDY);
  assign tx_ok      = PL2PE_Tx_ack && (PL2PE_Tx_result == 2'b00);
  assign tx_fail    = PL2PE_Tx_ack && (PL2PE_Tx_result != 2'b00);

  assign detach        = !DPM2PE_attached && (state != PE_SNK_STARTUP);
  assign state_changed = (state_next != state);
  assign pe_state      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PE_SNK_STARTUP;
    else        state <= state_next;
  end

  // Priority: detach, then received hard reset, then the per-state rules
  // where a received message always wins over a same-cycle timeout.
  always_comb begin
    state_next = state;
    if (detach) begin
      state_next = PE_SNK_STARTUP;
    end else if (PL2PE_Rx_hard_reset && state != PE_SNK_STARTUP &&
                 state != PE_SNK_HARD_RESET && state != PE_SNK_TRANSITION_TO_DEFAULT) begin
      state_next = PE_SNK_TRANSITION_TO_DEFAULT;
    end else begin
      case (state)
        PE_SNK_STARTUP:
          if (PL2PE_reset_done && DPM2PE_attached) state_next = PE_SNK_DISCOVERY;
        PE_SNK_DISCOVERY:
          if (DPM2PE_vbus_present) state_next = PE_SNK_WAIT_FOR_CAPS;
        PE_SNK_WAIT_FOR_CAPS:
          if (rx_src_cap)   state_next = PE_SNK_EVALUATE_CAP;
          else if (timeout) state_next = (hr_cnt <= HR_LIMIT) ? PE_SNK_HARD_RESET : PE_SNK_ERROR;
        PE_SNK_EVALUATE_CAP:
          if (DPM2PE_eval_done) state_next = PE_SNK_SELECT_CAP;
        PE_SNK_SELECT_CAP:
          if (rx_accept)                 state_next = PE_SNK_TRANSITION_SINK;
          else if (rx_reject || rx_wait) state_next = PE2DPM_contract_valid ? PE_SNK_READY
                                                                           : PE_SNK_WAIT_FOR_CAPS;
          else if (tx_fail || timeout)   state_next = PE_SNK_HARD_RESET;
        PE_SNK_TRANSITION_SINK:
          if (rx_ps_rdy)              state_next = PE_SNK_READY;
          else if (rx_msg || timeout) state_next = PE_SNK_HARD_RESET;
        PE_SNK_READY:
          if (rx_src_cap) state_next = PE_SNK_EVALUATE_CAP;
        PE_SNK_HARD_RESET:
          if (PL2PE_Tx_ack) state_next = PE_SNK_TRANSITION_TO_DEFAULT;
        PE_SNK_TRANSITION_TO_DEFAULT:
          if (DPM2PE_trans_finish) state_next = PE_SNK_STARTUP;
        PE_SNK_ERROR:
          state_next = PE_SNK_ERROR;
        default:
          state_next = PE_SNK_STARTUP;
      endcase
    end
  end

  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    if (entry && state == PE_SNK_WAIT_FOR_CAPS) begin
      timer_load = 1'b1;
      timer_val  = LD_SINKWAITCAP;
    end else if (entry && state == PE_SNK_TRANSITION_SINK) begin
      timer_load = 1'b1;
      timer_val  = LD_PSTRANSITION;
    end else if (state == PE_SNK_SELECT_CAP && tx_ok && !state_changed) begin
      timer_load = 1'b1;
      timer_val  = LD_SENDERRESPONSE;
    end
  end

  pd_pe_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .clear    (state_changed),
    .timeout  (timeout)
  );

  // Entry pulses are captured on the edge that changes state so they appear
  // exactly in the first cycle spent in the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry                 <= 1'b0;
      PE2PL_reset_req       <= 1'b0;
      PE2PL_Tx_en           <= 1'b0;
      PE2PL_Tx_type         <= '0;
      PE2PL_hard_reset_req  <= 1'b0;
      PE2DPM_eval_req       <= 1'b0;
      PE2DPM_hard_reset     <= 1'b0;
      PE2DPM_contract_valid <= 1'b0;
      hr_cnt                <= '0;
    end else begin
      entry                <= state_changed;
      PE2PL_reset_req      <= state_changed && (state_next == PE_SNK_STARTUP);
      PE2PL_Tx_en          <= state_changed && (state_next == PE_SNK_SELECT_CAP);
      PE2PL_hard_reset_req <= state_changed && (state_next == PE_SNK_HARD_RESET);
      PE2DPM_eval_req      <= state_changed && (state_next == PE_SNK_EVALUATE_CAP);
      PE2DPM_hard_reset    <= state_changed && (state_next == PE_SNK_TRANSITION_TO_DEFAULT);

      if (state_changed && state_next == PE_SNK_SELECT_CAP)
        PE2PL_Tx_type <= msg_code(MSG_CLASS_DATA, DATA_REQUEST);

      if (detach || (state_changed && state_next == PE_SNK_EVALUATE_CAP))
        hr_cnt <= '0;
      else if (state_changed && state_next == PE_SNK_HARD_RESET && hr_cnt != 3'd7)
        hr_cnt <= hr_cnt + 1'b1;

      if (detach || (state_changed && state_next == PE_SNK_TRANSITION_TO_DEFAULT))
        PE2DPM_contract_valid <= 1'b0;
      else if (state == PE_SNK_TRANSITION_SINK && state_next == PE_SNK_READY)
        PE2DPM_contract_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pd_snk_policy_engine.sv
// Directed bench for the sink policy engine: contract negotiation, missing
// capabilities, reject, PS_RDY timeout, received hard reset and detach.
module tb_pd_snk_policy_engine;

  localparam int TB_SINKWAIT = 100;
  localparam int TB_SENDRESP = 30;
  localparam int TB_PSTRANS  = 50;

  localparam logic [31:0] S_STARTUP = 32'd0;
  localparam logic [31:0] S_DISC    = 32'd1;
  localparam logic [31:0] S_WFC     = 32'd2;
  localparam logic [31:0] S_EVAL    = 32'd3;
  localparam logic [31:0] S_SELECT  = 32'd4;
  localparam logic [31:0] S_TSINK   = 32'd5;
  localparam logic [31:0] S_READY   = 32'd6;
  localparam logic [31:0] S_HRESET  = 32'd7;
  localparam logic [31:0] S_TTD     = 32'd8;
  localparam logic [31:0] S_ERROR   = 32'd9;

  localparam int K_RX    = 0;
  localparam int K_EVAL  = 1;
  localparam int K_TXACK = 2;
  localparam int K_TRANS = 3;
  localparam int K_HRST  = 4;
  localparam int K_RDONE = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       DPM2PE_attached;
  logic       DPM2PE_vbus_present;
  logic       DPM2PE_eval_done;
  logic       DPM2PE_trans_finish;
  logic       PL2PE_reset_done;
  logic       PL2PE_Rx_en;
  logic [6:0] PL2PE_Rx_type;
  logic       PL2PE_Rx_hard_reset;
  logic       PL2PE_Tx_ack;
  logic [1:0] PL2PE_Tx_result;
  logic       PE2PL_Tx_en;
  logic [6:0] PE2PL_Tx_type;
  logic       PE2PL_reset_req;
  logic       PE2PL_hard_reset_req;
  logic       PE2DPM_eval_req;
  logic       PE2DPM_hard_reset;
  logic       PE2DPM_contract_valid;
  logic [3:0] pe_state;

  int errors = 0;
  int checks = 0;
  int hr_model;
  logic [31:0] exp_state;

  always #5 clk = ~clk;

  pd_snk_policy_engine #(
    .T_SINKWAITCAP    (TB_SINKWAIT),
    .T_SENDERRESPONSE (TB_SENDRESP),
    .T_PSTRANSITION   (TB_PSTRANS)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .DPM2PE_attached       (DPM2PE_attached),
    .DPM2PE_vbus_present   (DPM2PE_vbus_present),
    .DPM2PE_eval_done      (DPM2PE_eval_done),
    .DPM2PE_trans_finish   (DPM2PE_trans_finish),
    .PL2PE_reset_done      (PL2PE_reset_done),
    .PL2PE_Rx_en           (PL2PE_Rx_en),
    .PL2PE_Rx_type         (PL2PE_Rx_type),
    .PL2PE_Rx_hard_reset   (PL2PE_Rx_hard_reset),
    .PL2PE_Tx_ack          (PL2PE_Tx_ack),
    .PL2PE_Tx_result       (PL2PE_Tx_result),
    .PE2PL_Tx_en           (PE2PL_Tx_en),
    .PE2PL_Tx_type         (PE2PL_Tx_type),
    .PE2PL_reset_req       (PE2PL_reset_req),
    .PE2PL_hard_reset_req  (PE2PL_hard_reset_req),
    .PE2DPM_eval_req       (PE2DPM_eval_req),
    .PE2DPM_hard_reset     (PE2DPM_hard_reset),
    .PE2DPM_contract_valid (PE2DPM_contract_valid),
    .pe_state              (pe_state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds one input pulse for exactly one clock edge, then idles all pulses.
  task automatic applyStimulus(input int kind, input logic [6:0] val);
    case (kind)
      K_RX:    begin PL2PE_Rx_en = 1'b1; PL2PE_Rx_type = val; end
      K_EVAL:  DPM2PE_eval_done = 1'b1;
      K_TXACK: begin PL2PE_Tx_ack = 1'b1; PL2PE_Tx_result = val[1:0]; end
      K_TRANS: DPM2PE_trans_finish = 1'b1;
      K_HRST:  PL2PE_Rx_hard_reset = 1'b1;
      K_RDONE: PL2PE_reset_done = 1'b1;
      default: ;
    endcase
    step();
    PL2PE_Rx_en         = 1'b0;
    PL2PE_Rx_type       = 7'd0;
    DPM2PE_eval_done    = 1'b0;
    PL2PE_Tx_ack        = 1'b0;
    PL2PE_Tx_result     = 2'b00;
    DPM2PE_trans_finish = 1'b0;
    PL2PE_Rx_hard_reset = 1'b0;
    PL2PE_reset_done    = 1'b0;
  endtask

  task automatic goToSelect();
    applyStimulus(K_RDONE, 7'd0);
    step();
    applyStimulus(K_RX, 7'h21);
    applyStimulus(K_EVAL, 7'd0);
    checkOutput("goto_select", 32'(pe_state), S_SELECT);
  endtask

  task automatic finishHardReset(input string tag);
    applyStimulus(K_TXACK, 7'd0);
    checkOutput({tag, "_ttd"}, 32'(pe_state), S_TTD);
    checkOutput({tag, "_dpm_hr"}, 32'(PE2DPM_hard_reset), 32'd1);
    applyStimulus(K_TRANS, 7'd0);
    checkOutput({tag, "_startup"}, 32'(pe_state), S_STARTUP);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n               = 1'b0;
    DPM2PE_attached     = 1'b0;
    DPM2PE_vbus_present = 1'b0;
    DPM2PE_eval_done    = 1'b0;
    DPM2PE_trans_finish = 1'b0;
    PL2PE_reset_done    = 1'b0;
    PL2PE_Rx_en         = 1'b0;
    PL2PE_Rx_type       = 7'd0;
    PL2PE_Rx_hard_reset = 1'b0;
    PL2PE_Tx_ack        = 1'b0;
    PL2PE_Tx_result     = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_state", 32'(pe_state), S_STARTUP);
    checkOutput("rst_pulses", 32'({PE2PL_Tx_en, PE2PL_reset_req, PE2PL_hard_reset_req,
                                   PE2DPM_eval_req, PE2DPM_hard_reset, PE2DPM_contract_valid}), 32'd0);
    checkOutput("rst_tx_type", 32'(PE2PL_Tx_type), 32'd0);
    rst_n = 1'b1;
    step();
    checkOutput("detached_idle", 32'(pe_state), S_STARTUP);

    // Nominal contract
    DPM2PE_attached     = 1'b1;
    DPM2PE_vbus_present = 1'b1;
    applyStimulus(K_RDONE, 7'd0);
    checkOutput("nom_discovery", 32'(pe_state), S_DISC);
    step();
    checkOutput("nom_wfc", 32'(pe_state), S_WFC);
    applyStimulus(K_RX, 7'h21);
    checkOutput("nom_eval", 32'(pe_state), S_EVAL);
    checkOutput("nom_eval_req", 32'(PE2DPM_eval_req), 32'd1);
    step();
    checkOutput("nom_eval_req_pulse", 32'(PE2DPM_eval_req), 32'd0);
    applyStimulus(K_EVAL, 7'd0);
    checkOutput("nom_select", 32'(pe_state), S_SELECT);
    checkOutput("nom_tx_en", 32'(PE2PL_Tx_en), 32'd1);
    checkOutput("nom_tx_type", 32'(PE2PL_Tx_type), 32'h22);
    applyStimulus(K_TXACK, 7'd0);
    checkOutput("nom_tx_ack_hold", 32'(pe_state), S_SELECT);
    checkOutput("nom_tx_en_pulse", 32'(PE2PL_Tx_en), 32'd0);
    applyStimulus(K_RX, 7'h03);
    checkOutput("nom_tsink", 32'(pe_state), S_TSINK);
    applyStimulus(K_RX, 7'h06);
    checkOutput("nom_ready", 32'(pe_state), S_READY);
    checkOutput("nom_contract", 32'(PE2DPM_contract_valid), 32'd1);
    applyStimulus(K_RX, 7'h01);
    checkOutput("goodcrc_ignored", 32'(pe_state), S_READY);

    // Hard reset received in READY
    applyStimulus(K_HRST, 7'd0);
    checkOutput("rxhr_ttd", 32'(pe_state), S_TTD);
    checkOutput("rxhr_contract", 32'(PE2DPM_contract_valid), 32'd0);
    checkOutput("rxhr_dpm_hr", 32'(PE2DPM_hard_reset), 32'd1);
    checkOutput("rxhr_no_hr_req", 32'(PE2PL_hard_reset_req), 32'd0);
    applyStimulus(K_TRANS, 7'd0);
    checkOutput("rxhr_startup", 32'(pe_state), S_STARTUP);
    checkOutput("rxhr_reset_req", 32'(PE2PL_reset_req), 32'd1);

    // No capabilities: three hard resets, then ERROR on the fourth timeout
    hr_model = 0;
    for (int round = 1; round <= 4; round++) begin
      applyStimulus(K_RDONE, 7'd0);
      step();
      checkOutput("nocap_wfc_entry", 32'(pe_state), S_WFC);
      repeat (TB_SINKWAIT) step();
      checkOutput("nocap_wfc_hold", 32'(pe_state), S_WFC);
      step();
      exp_state = (hr_model <= 2) ? S_HRESET : S_ERROR;
      checkOutput("nocap_timeout", 32'(pe_state), exp_state);
      if (exp_state == S_HRESET) begin
        checkOutput("nocap_hr_req", 32'(PE2PL_hard_reset_req), 32'd1);
        hr_model++;
        PL2PE_Tx_result = 2'b01;
        applyStimulus(K_TXACK, 7'h01);
        checkOutput("nocap_ttd", 32'(pe_state), S_TTD);
        applyStimulus(K_TRANS, 7'd0);
        checkOutput("nocap_startup", 32'(pe_state), S_STARTUP);
      end
    end
    repeat (5) step();
    checkOutput("error_hold", 32'(pe_state), S_ERROR);
    DPM2PE_attached = 1'b0;
    step();
    checkOutput("error_detach", 32'(pe_state), S_STARTUP);
    DPM2PE_attached = 1'b1;

    // Reject before any contract
    goToSelect();
    applyStimulus(K_RX, 7'h04);
    checkOutput("reject_wfc", 32'(pe_state), S_WFC);
    checkOutput("reject_contract", 32'(PE2DPM_contract_valid), 32'd0);

    // PS_RDY never arrives
    applyStimulus(K_RX, 7'h21);
    applyStimulus(K_EVAL, 7'd0);
    applyStimulus(K_TXACK, 7'd0);
    applyStimulus(K_RX, 7'h03);
    checkOutput("psrdy_tsink", 32'(pe_state), S_TSINK);
    repeat (TB_PSTRANS) step();
    checkOutput("psrdy_hold", 32'(pe_state), S_TSINK);
    step();
    checkOutput("psrdy_hr", 32'(pe_state), S_HRESET);
    checkOutput("psrdy_hr_req", 32'(PE2PL_hard_reset_req), 32'd1);
    finishHardReset("psrdy");

    // Request transmit failure
    goToSelect();
    applyStimulus(K_TXACK, 7'h02);
    checkOutput("txfail_hr", 32'(pe_state), S_HRESET);
    finishHardReset("txfail");

    // No response to Request
    goToSelect();
    applyStimulus(K_TXACK, 7'd0);
    repeat (TB_SENDRESP - 1) step();
    checkOutput("sendresp_hold", 32'(pe_state), S_SELECT);
    step();
    checkOutput("sendresp_hr", 32'(pe_state), S_HRESET);
    finishHardReset("sendresp");

    // Detach with the SenderResponse timer running
    goToSelect();
    applyStimulus(K_TXACK, 7'd0);
    repeat (5) step();
    DPM2PE_attached = 1'b0;
    step();
    checkOutput("detach_startup", 32'(pe_state), S_STARTUP);
    checkOutput("detach_reset_req", 32'(PE2PL_reset_req), 32'd1);
    step();
    checkOutput("detach_reset_req_pulse", 32'(PE2PL_reset_req), 32'd0);
    repeat (40) step();
    checkOutput("detach_stay", 32'(pe_state), S_STARTUP);
    checkOutput("detach_no_hr", 32'(PE2PL_hard_reset_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
